// File: rtl/seq_signed_divider_if.sv
// Operand/result handshake for the sequential signed divider.
// The master issues operands with ivalid; the slave answers with an ovalid pulse.
interface seq_signed_divider_if #(
    parameter int DIVIDEND = 32,
    parameter int DIVISOR  = 24
);
    logic                       ivalid;
    logic signed [DIVISOR-1:0]  divisor;
    logic signed [DIVIDEND-1:0] dividend;
    logic                       ovalid;
    logic signed [DIVIDEND-1:0] quotient;

    modport master (output ivalid, divisor, dividend, input ovalid, quotient);
    modport slave  (input ivalid, divisor, dividend, output ovalid, quotient);
endinterface

// File: rtl/seq_signed_divider.sv
// Iterative signed divider: restoring shift-subtract on magnitudes, one quotient
// bit per clock, sign and saturation applied in a final cycle.
module seq_signed_divider #(
    parameter int DIVIDEND = 32,
    parameter int DIVISOR  = 24
) (
    input logic                 clock,
    input logic                 reset,
    seq_signed_divider_if.slave bus
);
    localparam int CW = $clog2(DIVIDEND + 1);
    localparam logic [DIVIDEND-1:0] Q_MAX = {1'b0, {(DIVIDEND-1){1'b1}}};
    localparam logic [DIVIDEND-1:0] Q_MIN = {1'b1, {(DIVIDEND-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t              state_reg, state_next;
    logic [DIVIDEND-1:0] dq_reg;
    logic [DIVISOR-1:0]  dv_reg;
    logic [DIVISOR:0]    rem_reg;
    logic [CW-1:0]       count_reg;
    logic                neg_reg, dz_reg, dd_neg_reg;
    logic [DIVIDEND-1:0] quotient_reg;
    logic                ovalid_reg;

    logic [DIVIDEND-1:0] dd_raw, dd_mag;
    logic [DIVISOR-1:0]  dv_raw, dv_mag;
    logic                start;
    logic [DIVISOR:0]    shifted, trial;
    logic                fits;
    logic [DIVIDEND-1:0] result_value;

    // Magnitudes of the incoming operands; the most-negative value maps to 2^(W-1).
    always_comb begin
        dd_raw = bus.dividend;
        dv_raw = bus.divisor;
        dd_mag = dd_raw[DIVIDEND-1] ? (~dd_raw + DIVIDEND'(1)) : dd_raw;
        dv_mag = dv_raw[DIVISOR-1]  ? (~dv_raw + DIVISOR'(1))  : dv_raw;
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = CALC;
            CALC:    if (count_reg == '0) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output / datapath control logic
    always_comb begin
        // A request arriving while the previous result is being presented is dropped.
        start   = (state_reg == IDLE) && bus.ivalid && !ovalid_reg;
        shifted = {rem_reg[DIVISOR-1:0], dq_reg[DIVIDEND-1]};
        trial   = shifted - {1'b0, dv_reg};
        fits    = (shifted >= {1'b0, dv_reg});
        if (dz_reg) begin
            result_value = dd_neg_reg ? Q_MIN : Q_MAX;
        end else if (neg_reg) begin
            result_value = ~dq_reg + DIVIDEND'(1);
        end else if (dq_reg[DIVIDEND-1]) begin
            // Only -2^(W-1) / -1 yields a positive magnitude this large.
            result_value = Q_MAX;
        end else begin
            result_value = dq_reg;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            dq_reg       <= '0;
            dv_reg       <= '0;
            rem_reg      <= '0;
            count_reg    <= '0;
            neg_reg      <= 1'b0;
            dz_reg       <= 1'b0;
            dd_neg_reg   <= 1'b0;
            quotient_reg <= '0;
            ovalid_reg   <= 1'b0;
        end else begin
            ovalid_reg <= (state_reg == DONE);
            if (start) begin
                dq_reg     <= dd_mag;
                dv_reg     <= dv_mag;
                rem_reg    <= '0;
                count_reg  <= CW'(DIVIDEND - 1);
                neg_reg    <= dd_raw[DIVIDEND-1] ^ dv_raw[DIVISOR-1];
                dz_reg     <= (dv_raw == '0);
                dd_neg_reg <= dd_raw[DIVIDEND-1];
            end
            if (state_reg == CALC) begin
                rem_reg   <= fits ? trial : shifted;
                dq_reg    <= {dq_reg[DIVIDEND-2:0], fits};
                count_reg <= count_reg - CW'(1);
            end
            if (state_reg == DONE) begin
                quotient_reg <= result_value;
            end
        end
    end

    assign bus.ovalid   = ovalid_reg;
    assign bus.quotient = quotient_reg;
endmodule

// File: tb/tb_seq_signed_divider.sv
// Directed and random bench for seq_signed_divider with a queue scoreboard
// and an independent truncating-division reference model.
module tb_seq_signed_divider;
    localparam int DD  = 32;
    localparam int DV  = 24;
    localparam int LAT = DD + 1;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   tests = 0;
    int   fails = 0;
    logic [DD-1:0] sb[$];

    always #5 clock = ~clock;

    seq_signed_divider_if #(.DIVIDEND(DD), .DIVISOR(DV)) bus ();

    seq_signed_divider #(.DIVIDEND(DD), .DIVISOR(DV)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    function automatic logic [DD-1:0] ref_div(input logic [DD-1:0] dd, input logic [DV-1:0] dv);
        longint a, b, q;
        a = longint'($signed(dd));
        b = longint'($signed(dv));
        if (b == 0) return (a < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
        q = a / b;
        if (q > 64'sd2147483647) return 32'h7FFF_FFFF;
        return q[DD-1:0];
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [DD-1:0] obs, input logic [DD-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    // Drive one ivalid cycle; scoreboard only requests the DUT is expected to accept.
    task automatic pulse(input logic [DD-1:0] dd, input logic [DV-1:0] dv, input bit expect_accept);
        bus.dividend = dd;
        bus.divisor  = dv;
        bus.ivalid   = 1'b1;
        if (expect_accept) sb.push_back(ref_div(dd, dv));
        tick();
        bus.ivalid = 1'b0;
        $display("[TB] issue %0d / %0d accept=%0d", $signed(dd), $signed(dv), expect_accept);
    endtask

    task automatic wait_result(input int exp_lat, input string name);
        int cnt;
        bit stable;
        logic [DD-1:0] held, exp_q;
        cnt = 0;
        stable = 1'b1;
        held = bus.quotient;
        while (bus.ovalid !== 1'b1 && cnt < 200) begin
            tick();
            cnt++;
            if (bus.ovalid !== 1'b1 && bus.quotient !== held) stable = 1'b0;
        end
        if (bus.ovalid !== 1'b1) begin
            check({name, " timeout"}, 32'd0, 32'd1);
            return;
        end
        check({name, " latency"}, DD'(cnt), DD'(exp_lat));
        check({name, " hold"}, DD'(stable), 32'd1);
        if (sb.size() == 0) begin
            check({name, " unexpected result"}, 32'd0, 32'd1);
        end else begin
            exp_q = sb.pop_front();
            check({name, " quotient"}, bus.quotient, exp_q);
            $display("[TB] result %s q=%0d exp=%0d", name, $signed(bus.quotient), $signed(exp_q));
        end
    endtask

    task automatic pulse_end(input string name);
        tick();
        check({name, " ovalid width"}, DD'(bus.ovalid), 32'd0);
    endtask

    task automatic quiet(input int cycles, input string name);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (bus.ovalid === 1'b1) seen++;
        end
        check({name, " no extra ovalid"}, DD'(seen), 32'd0);
    endtask

    task automatic run_one(input logic [DD-1:0] dd, input logic [DV-1:0] dv, input string name);
        pulse(dd, dv, 1'b1);
        wait_result(LAT, name);
        pulse_end(name);
    endtask

    initial begin
        logic [DD-1:0] rdd;
        logic [DV-1:0] rdv;
        bus.ivalid   = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check("reset ovalid", DD'(bus.ovalid), 32'd0);
        check("reset quotient", bus.quotient, 32'd0);

        run_one(32'd100, 24'd5, "100/5");
        run_one(-32'sd100, 24'd5, "-100/5");
        run_one(32'd103, -24'sd5, "103/-5");
        run_one(-32'sd100, -24'sd5, "-100/-5");
        run_one(-32'sd7, 24'd2, "-7/2");
        run_one(32'd0, 24'd5, "0/5");
        run_one(32'd0, -24'sd5, "0/-5");
        run_one(32'd7, 24'd0, "7/0");
        run_one(-32'sd7, 24'd0, "-7/0");
        run_one(32'h8000_0000, -24'sd1, "min/-1");
        run_one(32'h8000_0000, 24'd1, "min/1");
        run_one(32'h7FFF_FFFF, 24'h80_0000, "max/dvmin");

        // Re-pulse mid-computation must be ignored.
        pulse(32'd100, 24'd5, 1'b1);
        repeat (4) tick();
        pulse(32'd9, 24'd3, 1'b0);
        wait_result(LAT - 5, "repulse");
        // ivalid during the ovalid cycle must be ignored as well.
        pulse(32'd55, 24'd11, 1'b0);
        check("ovalid cycle drop", DD'(bus.ovalid), 32'd0);
        quiet(40, "repulse");
        run_one(32'd9, 24'd3, "9/3");

        // Reset mid-division discards the work in flight.
        pulse(32'd70, 24'd3, 1'b0);
        repeat (9) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midreset ovalid", DD'(bus.ovalid), 32'd0);
        check("midreset quotient", bus.quotient, 32'd0);
        quiet(40, "midreset");
        run_one(32'd50, -24'sd7, "50/-7");

        for (int i = 0; i < 20; i++) begin
            rdd = $urandom;
            rdv = DV'($urandom);
            if (i % 3 == 0) rdv = DV'($urandom_range(1, 300));
            if (rdv == '0) rdv = 24'd13;
            if (rdd == 32'h8000_0000 && rdv == 24'hFF_FFFF) rdv = 24'd2;
            run_one(rdd, rdv, $sformatf("rand%0d", i));
        end

        check("scoreboard drained", DD'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
